// File: rtl/imem_loadable_if.sv
// Fetch and loader buses of the loadable instruction memory.
// master: IF stage plus boot loader; slave: the memory block.
interface imem_loadable_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
);
  logic              fetch_en;
  logic [31:0]       fetch_addr;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              run;
  logic              ld_overflow;
  logic [DEPTH_LOG2:0] ld_count;

  modport master (
    output fetch_en, fetch_addr, stall, flush, ld_start, ld_valid, ld_data, ld_last,
    input  instr, instr_valid, addr_fault, ld_ready, run, ld_overflow, ld_count
  );

  modport slave (
    input  fetch_en, fetch_addr, stall, flush, ld_start, ld_valid, ld_data, ld_last,
    output instr, instr_valid, addr_fault, ld_ready, run, ld_overflow, ld_count
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable synchronous instruction memory: streams a program in (LOAD),
// then serves one-cycle-latency fetches with stall/flush and address faults (RUN).
module imem_loadable #(
  parameter int                DEPTH_LOG2 = 8,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
  input  logic           clk,
  input  logic           reset,
  imem_loadable_if.slave bus
);
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] WP_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_en;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic                  fetch_flt;
  logic [DATA_W-1:0]     instr_p1;
  logic                  vld_p1;
  logic                  flt_p1;

  function automatic logic addr_fault_f(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (bus.ld_valid) begin
          wr_en = 1'b1;
          wp_d  = wp_q + WP_ONE;
          cnt_d = cnt_q + CNT_ONE;
          if (bus.ld_last) begin
            state_d = ST_RUN;
          end else if (&wp_q) begin
            // Image filled the array without a terminator: stop accepting.
            ovf_d   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.ld_start) begin
          state_d = ST_LOAD;
          wp_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Loader write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= bus.ld_data;
    end
  end

  assign fetch_idx = bus.fetch_addr[DEPTH_LOG2+1:2];
  assign fetch_flt = addr_fault_f(bus.fetch_addr);

  // Stage p1: registered fetch result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      flt_p1   <= 1'b0;
    end else if (state_q != ST_RUN || bus.ld_start) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      flt_p1   <= 1'b0;
    end else if (bus.flush) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      flt_p1   <= 1'b0;
    end else if (bus.stall) begin
      instr_p1 <= instr_p1;
      vld_p1   <= vld_p1;
      flt_p1   <= flt_p1;
    end else if (bus.fetch_en && fetch_flt) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      flt_p1   <= 1'b1;
    end else if (bus.fetch_en) begin
      instr_p1 <= mem[fetch_idx];
      vld_p1   <= 1'b1;
      flt_p1   <= 1'b0;
    end else begin
      vld_p1   <= 1'b0;
      flt_p1   <= 1'b0;
    end
  end

  assign bus.instr       = instr_p1;
  assign bus.instr_valid = vld_p1;
  assign bus.addr_fault  = flt_p1;
  assign bus.run         = (state_q == ST_RUN);
  assign bus.ld_ready    = (state_q == ST_LOAD);
  assign bus.ld_overflow = ovf_q;
  assign bus.ld_count    = cnt_q;
endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a 256-word instance for load/fetch/fault/reload/reset
// and an 8-word instance for overflow; a negedge monitor pops and compares expectations.
module tb_imem_loadable;
  localparam logic [31:0] NOP = 32'h0;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drain = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loadable_if #(.DATA_W(32), .DEPTH_LOG2(8)) ifa ();
  imem_loadable_if #(.DATA_W(32), .DEPTH_LOG2(3)) ifb ();

  imem_loadable #(.DEPTH_LOG2(8), .DATA_W(32), .NOP_WORD(32'h0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  imem_loadable #(.DEPTH_LOG2(3), .DATA_W(32), .NOP_WORD(32'h0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    string       name;
    int          due;
    bit          dut;
    bit          stat;
    bit          mask;
    logic [31:0] instr;
    bit          vld;
    bit          flt;
    bit          run;
    bit          rdy;
    bit          ovf;
    int          cnt;
  } exp_t;

  exp_t sbq[$];

  task automatic exp_out(input string nm, input bit d, input int due, input logic [31:0] ins,
                         input bit v, input bit f, input bit m);
    exp_t e;
    e.name = nm; e.due = due; e.dut = d; e.stat = 1'b0; e.mask = m;
    e.instr = ins; e.vld = v; e.flt = f; e.run = 1'b0; e.rdy = 1'b0; e.ovf = 1'b0; e.cnt = 0;
    sbq.push_back(e);
  endtask

  task automatic exp_st(input string nm, input bit d, input int due, input bit r, input bit rd,
                        input bit o, input int c);
    exp_t e;
    e.name = nm; e.due = due; e.dut = d; e.stat = 1'b1; e.mask = 1'b0;
    e.instr = NOP; e.vld = 1'b0; e.flt = 1'b0; e.run = r; e.rdy = rd; e.ovf = o; e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation that falls due on this cycle
  exp_t        mon_e;
  logic [31:0] act_i;
  logic        act_v, act_f, act_r, act_rd, act_o;
  int          act_c;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      act_i  = mon_e.dut ? ifb.instr       : ifa.instr;
      act_v  = mon_e.dut ? ifb.instr_valid : ifa.instr_valid;
      act_f  = mon_e.dut ? ifb.addr_fault  : ifa.addr_fault;
      act_r  = mon_e.dut ? ifb.run         : ifa.run;
      act_rd = mon_e.dut ? ifb.ld_ready    : ifa.ld_ready;
      act_o  = mon_e.dut ? ifb.ld_overflow : ifa.ld_overflow;
      act_c  = mon_e.dut ? int'(ifb.ld_count) : int'(ifa.ld_count);
      if (mon_e.due < cyc) begin
        n_bad++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", mon_e.name, mon_e.due, cyc);
      end else if (!mon_e.stat) begin
        if (act_v !== mon_e.vld || act_f !== mon_e.flt || (!mon_e.mask && act_i !== mon_e.instr)) begin
          n_bad++;
          $display("FAIL %s: got instr=%h valid=%b fault=%b, want instr=%h valid=%b fault=%b%s",
                   mon_e.name, act_i, act_v, act_f, mon_e.instr, mon_e.vld, mon_e.flt,
                   mon_e.mask ? " (instr ignored)" : "");
        end
      end else begin
        if (act_r !== mon_e.run || act_rd !== mon_e.rdy || act_o !== mon_e.ovf || act_c != mon_e.cnt) begin
          n_bad++;
          $display("FAIL %s: got run=%b ld_ready=%b ld_overflow=%b ld_count=%0d, want run=%b ld_ready=%b ld_overflow=%b ld_count=%0d",
                   mon_e.name, act_r, act_rd, act_o, act_c, mon_e.run, mon_e.rdy, mon_e.ovf, mon_e.cnt);
        end
      end
    end
    if (drain) begin
      while (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: never checked (due cycle %0d)", mon_e.name, mon_e.due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] prog [4];
  int          fa [3];

  initial begin
    prog[0] = 32'h20100001; prog[1] = 32'h20110002; prog[2] = 32'h02119020; prog[3] = 32'h00000000;
    fa[0] = 0; fa[1] = 4; fa[2] = 8;
    reset = 1'b0;
    ifa.fetch_en = 0; ifa.fetch_addr = 0; ifa.stall = 0; ifa.flush = 0;
    ifa.ld_start = 0; ifa.ld_valid = 0; ifa.ld_data = 0; ifa.ld_last = 0;
    ifb.fetch_en = 0; ifb.fetch_addr = 0; ifb.stall = 0; ifb.flush = 0;
    ifb.ld_start = 0; ifb.ld_valid = 0; ifb.ld_data = 0; ifb.ld_last = 0;
    tick(); tick();
    exp_st("reset_status_a", 0, cyc, 0, 1, 0, 0);
    exp_out("reset_out_a", 0, cyc, NOP, 0, 0, 0);
    exp_st("reset_status_b", 1, cyc, 0, 1, 0, 0);
    tick();
    reset = 1'b1;

    // Load the 4-word program; fetch requests during LOAD are ignored
    for (int i = 0; i < 4; i++) begin
      ifa.ld_valid = 1; ifa.ld_data = prog[i]; ifa.ld_last = (i == 3);
      ifa.fetch_en = 1; ifa.fetch_addr = 0;
      if (i == 1) exp_out("fetch_during_load", 0, cyc + 1, NOP, 0, 0, 0);
      if (i == 2) exp_st("mid_load_count", 0, cyc + 1, 0, 1, 0, 3);
      if (i == 3) exp_st("load_done", 0, cyc + 1, 1, 0, 0, 4);
      tick();
    end
    ifa.ld_valid = 0; ifa.ld_last = 0;

    for (int k = 0; k < 3; k++) begin
      ifa.fetch_addr = fa[k];
      exp_out($sformatf("fetch_%0d", fa[k]), 0, cyc + 1, prog[k], 1, 0, 0);
      tick();
    end

    // Stall holds, flush overrides stall
    ifa.fetch_addr = 4;
    exp_out("fetch_4_pre_stall", 0, cyc + 1, prog[1], 1, 0, 0);
    tick();
    ifa.stall = 1; ifa.fetch_addr = 8;
    for (int k = 0; k < 3; k++) begin
      exp_out($sformatf("stall_hold_%0d", k), 0, cyc + 1, prog[1], 1, 0, 0);
      tick();
    end
    ifa.flush = 1;
    exp_out("flush_over_stall", 0, cyc + 1, NOP, 0, 0, 0);
    tick();
    ifa.flush = 0; ifa.stall = 0;
    exp_out("fetch_8", 0, cyc + 1, prog[2], 1, 0, 0);
    tick();
    ifa.fetch_en = 0;
    exp_out("idle_holds_instr", 0, cyc + 1, prog[2], 0, 0, 0);
    tick();

    // Faults
    ifa.fetch_en = 1; ifa.fetch_addr = 32'h6;
    exp_out("fault_misaligned", 0, cyc + 1, NOP, 0, 1, 0);
    tick();
    ifa.stall = 1; ifa.fetch_addr = 0;
    exp_out("stall_holds_fault", 0, cyc + 1, NOP, 0, 1, 0);
    tick();
    ifa.stall = 0; ifa.fetch_addr = 32'h400;
    exp_out("fault_range_400", 0, cyc + 1, NOP, 0, 1, 0);
    tick();
    ifa.fetch_addr = 32'h3FC;
    exp_out("no_fault_3fc", 0, cyc + 1, NOP, 1, 0, 1);
    tick();
    ifa.fetch_addr = 32'h8000_0000;
    exp_out("fault_high_bit", 0, cyc + 1, NOP, 0, 1, 0);
    tick();

    // Reload: ld_start beats stall and the pending fetch
    ifa.fetch_addr = 0; ifa.ld_start = 1; ifa.stall = 1;
    exp_out("reload_squash", 0, cyc + 1, NOP, 0, 0, 0);
    exp_st("reload_status", 0, cyc + 1, 0, 1, 0, 0);
    tick();
    ifa.stall = 0;
    ifa.ld_valid = 1; ifa.ld_data = 32'hAAAA0001; ifa.ld_last = 0;
    exp_st("ld_start_in_load_ignored", 0, cyc + 1, 0, 1, 0, 1);
    tick();
    ifa.ld_start = 0; ifa.ld_data = 32'hBBBB0002; ifa.ld_last = 1;
    exp_st("reload_done", 0, cyc + 1, 1, 0, 0, 2);
    tick();
    ifa.ld_valid = 0; ifa.ld_last = 0;
    ifa.fetch_addr = 0;
    exp_out("reload_fetch_0", 0, cyc + 1, 32'hAAAA0001, 1, 0, 0);
    tick();
    ifa.fetch_addr = 4;
    exp_out("reload_fetch_4", 0, cyc + 1, 32'hBBBB0002, 1, 0, 0);
    tick();
    ifa.fetch_addr = 8;
    exp_out("reload_keeps_8", 0, cyc + 1, prog[2], 1, 0, 0);
    tick();

    // Async reset mid-load
    ifa.fetch_en = 0; ifa.ld_start = 1;
    tick();
    ifa.ld_start = 0;
    ifa.ld_valid = 1; ifa.ld_data = 32'h11110000;
    exp_st("midload_word1", 0, cyc + 1, 0, 1, 0, 1);
    tick();
    ifa.ld_data = 32'h22220004;
    tick();
    ifa.ld_valid = 0;
    reset = 1'b0;
    exp_st("async_reset_status", 0, cyc, 0, 1, 0, 0);
    exp_out("async_reset_out", 0, cyc, NOP, 0, 0, 0);
    tick();
    reset = 1'b1;
    exp_st("after_reset_release", 0, cyc, 0, 1, 0, 0);
    tick();
    ifa.ld_valid = 1; ifa.ld_data = 32'h33330000; ifa.ld_last = 1;
    exp_st("post_reset_load", 0, cyc + 1, 1, 0, 0, 1);
    tick();
    ifa.ld_valid = 0; ifa.ld_last = 0;
    ifa.fetch_en = 1; ifa.fetch_addr = 0;
    exp_out("post_reset_fetch_0", 0, cyc + 1, 32'h33330000, 1, 0, 0);
    tick();
    ifa.fetch_addr = 4;
    exp_out("mem_kept_fetch_4", 0, cyc + 1, 32'h22220004, 1, 0, 0);
    tick();
    ifa.fetch_en = 0;

    // Overflow on the 8-word instance
    for (int i = 0; i < 10; i++) begin
      ifb.ld_valid = 1; ifb.ld_data = 32'h100 + i; ifb.ld_last = 0;
      if (i == 6) exp_st("ovf_before_full", 1, cyc + 1, 0, 1, 0, 7);
      if (i == 7) exp_st("ovf_set", 1, cyc + 1, 1, 0, 1, 8);
      if (i == 9) exp_st("ovf_extra_ignored", 1, cyc + 1, 1, 0, 1, 8);
      tick();
    end
    ifb.ld_valid = 0;
    ifb.fetch_en = 1; ifb.fetch_addr = 0;
    exp_out("ovf_fetch_0", 1, cyc + 1, 32'h100, 1, 0, 0);
    tick();
    ifb.fetch_addr = 28;
    exp_out("ovf_fetch_28", 1, cyc + 1, 32'h107, 1, 0, 0);
    tick();
    ifb.fetch_addr = 32;
    exp_out("small_fault_32", 1, cyc + 1, NOP, 0, 1, 0);
    tick();
    ifb.fetch_addr = 4;
    exp_out("ovf_fetch_4", 1, cyc + 1, 32'h101, 1, 0, 0);
    tick();
    ifb.fetch_en = 0;

    tick(); tick();
    drain = 1'b1;
    tick(); tick();
  end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised synchronous instruction memory for the pipelined MIPS core, replacing the fixed combinational program ROM. It sits between the IF stage and an external word-stream loader, for example the UART boot path. After reset it accepts a program as a stream of 32-bit words, then serves one-cycle-latency fetches with stall and flush support. It also flags misaligned and out-of-range fetch addresses.

## Interface
Parameters:
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 words (default 256, covering byte addresses 0x000–0x3FC).
- `DATA_W`, default 32: instruction width.
- `NOP_WORD`, default 32'h00000000: word driven on fault, flush or not-ready.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `fetch_en`, input, 1: IF stage requests the word at `fetch_addr`.
- `fetch_addr`, input, 32: byte address (the PC).
- `stall`, input, 1: hold `instr`, `instr_valid` and `addr_fault`.
- `flush`, input, 1: squash the next registered output.
- `instr`, output, DATA_W: registered instruction.
- `instr_valid`, output, 1: `instr` holds a real fetched word.
- `addr_fault`, output, 1: the registered fetch was misaligned or out of range.
- `ld_start`, input, 1: pulse in RUN to re-enter LOAD.
- `ld_valid`, input, 1: loader word available.
- `ld_data`, input, DATA_W: loader word.
- `ld_last`, input, 1: the current loader word is the final one.
- `ld_ready`, output, 1: the block accepts loader words.
- `run`, output, 1: the program is loaded and the CPU may fetch.
- `ld_overflow`, output, 1: sticky flag; the image filled the memory without `ld_last`.
- `ld_count`, output, DEPTH_LOG2+1: number of words written in the last or current load.

## Operation
- The FSM has two states: LOAD and RUN. Reset enters LOAD.
- Reset values:
  - state = LOAD, write pointer = 0
  - `ld_count` = 0, `ld_overflow` = 0, `run` = 0, `ld_ready` = 1
  - `instr` = NOP_WORD, `instr_valid` = 0, `addr_fault` = 0
  - Memory array contents are not cleared.
- LOAD:
  - `ld_ready` = 1 and `run` = 0.
  - On `ld_valid`, write `ld_data` to mem[wp], increment wp, and increment `ld_count`.
  - If the accepted word has `ld_last` = 1, go to RUN.
  - If the accepted word is at wp = 2^DEPTH_LOG2−1 and `ld_last` = 0, set `ld_overflow` and go to RUN. Subsequent `ld_valid` is ignored because `ld_ready` = 0.
  - Fetches are ignored: `instr` = NOP_WORD, `instr_valid` = 0.
- RUN:
  - `ld_ready` = 0 and `run` = 1.
  - `ld_start` = 1 resets wp and `ld_count` to 0, clears `ld_overflow`, and returns to LOAD.
  - `ld_start` in LOAD is ignored.
- Fetch decode (RUN only):
  - index = `fetch_addr`[DEPTH_LOG2+1:2].
  - fault = (`fetch_addr`[1:0] != 0) OR (`fetch_addr`[31:DEPTH_LOG2+2] != 0).
- Output register update priority, highest first:
  1. state != RUN, or `ld_start` this cycle: `instr` = NOP_WORD, `instr_valid` = 0, `addr_fault` = 0.
  2. `flush`: `instr` = NOP_WORD, `instr_valid` = 0, `addr_fault` = 0 (flush overrides stall).
  3. `stall`: hold all three outputs.
  4. `fetch_en` with fault: `instr` = NOP_WORD, `instr_valid` = 0, `addr_fault` = 1.
  5. `fetch_en` without fault: `instr` = mem[index], `instr_valid` = 1, `addr_fault` = 0.
  6. Otherwise: `instr_valid` = 0, `addr_fault` = 0, `instr` holds.
- Reads and writes never occur in the same state, so there is no read/write collision case.

## Timing
- Fetch latency is 1 cycle: an address presented at edge N is reflected in `instr` after edge N+1.
- One fetch per cycle with no wait states.
- Loader throughput is one word per cycle while `ld_valid` and `ld_ready` are both high.
- The word with `ld_last` is written on edge N, `run` = 1 after edge N, and the first fetch is registered at edge N+1.
- The transition on `ld_start` takes effect on the same edge; `run` drops after that edge.
- Asserting `reset` mid-load or mid-run immediately clears all registered outputs and the FSM state, with no wait for `clk`.
- Memory keeps its content, but `run` stays 0 until a new load finishes.

## Test plan
- **Load and run:** load 4 words 0x20100001, 0x20110002, 0x02119020, 0x00000000, the last with `ld_last`. Then `run` = 1 and `ld_count` = 4. Fetch addresses 0, 4, 8 back to back → `instr` = 0x20100001, 0x20110002, 0x02119020 on consecutive cycles, each with `instr_valid` = 1.
- **Stall and flush:** fetch 0x4 with `stall` held 3 cycles → `instr` stays 0x20110002. Assert `flush` together with `stall` → next cycle `instr` = 0, `instr_valid` = 0.
- **Faults:** fetch 0x6 → `addr_fault` = 1, `instr` = 0. Fetch 0x400 with DEPTH_LOG2 = 8 → `addr_fault` = 1. Fetch 0x3FC → no fault.
- **Overflow:** with DEPTH_LOG2 = 3, stream 10 words without `ld_last` → after word 8, `ld_overflow` = 1, `run` = 1, `ld_ready` = 0, `ld_count` = 8. Words 9 and 10 are not written.
- **Reload:** in RUN, pulse `ld_start` while `fetch_en` = 1 → `run` = 0 and `instr_valid` = 0 after the edge. Load 2 new words → fetch 0 returns the new word 0.
- **Async reset mid-load:** drop `reset` between `clk` edges after 2 of 4 words → all outputs go to reset values immediately. After release the block is in LOAD, `ld_count` = 0 and `ld_ready` = 1.
